// File: rtl/hex_pkg.sv
// Shared constants for the Intel-HEX load sequencer: FSM encodings, fail causes,
// ASCII codes and a hex-digit classifier used by the record tracker.
package hex_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_RSTC = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_FEED = 3'd3;
   localparam logic [2:0] ST_GAP  = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;
   localparam logic [2:0] ST_FAIL = 3'd6;

   localparam logic [1:0] CAUSE_NONE  = 2'd0;
   localparam logic [1:0] CAUSE_CSUM  = 2'd1;
   localparam logic [1:0] CAUSE_TMO   = 2'd2;
   localparam logic [1:0] CAUSE_ABORT = 2'd3;

   localparam logic [7:0] ASC_COLON = 8'h3A;
   localparam logic [7:0] ASC_ZERO  = 8'h30;
   localparam logic [7:0] ASC_ONE   = 8'h31;

   function automatic logic isHexDigit(input logic [7:0] c);
      return ((c >= 8'h30) && (c <= 8'h39)) ||
             ((c >= 8'h41) && (c <= 8'h46)) ||
             ((c >= 8'h61) && (c <= 8'h66));
   endfunction

endpackage

// File: rtl/hex_rec_trk.sv
// Follows the character stream fed to the converter: counts records, indexes hex
// digits within the current record and flags when an EOF record has been fully fed.
module hex_rec_trk
   import hex_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        feed_i,
   input  logic [7:0]  char_i,
   output logic [15:0] recCnt_o,
   output logic        eofDone_o
);

   logic [3:0]  idx_q, idx_d;
   logic        d7Zero_q, d7Zero_d;
   logic        isEof_q, isEof_d;
   logic        eofDone_q, eofDone_d;
   logic [15:0] recCnt_q, recCnt_d;

   // Digit index is 1-based after ':'; type digits are 7..8, last checksum digit is 10.
   always_comb begin
      idx_d     = idx_q;
      d7Zero_d  = d7Zero_q;
      isEof_d   = isEof_q;
      eofDone_d = eofDone_q;
      recCnt_d  = recCnt_q;
      if (clear_i) begin
         idx_d     = '0;
         d7Zero_d  = 1'b0;
         isEof_d   = 1'b0;
         eofDone_d = 1'b0;
         recCnt_d  = '0;
      end else if (feed_i) begin
         if (char_i == ASC_COLON) begin
            idx_d     = '0;
            d7Zero_d  = 1'b0;
            isEof_d   = 1'b0;
            eofDone_d = 1'b0;
            if (recCnt_q != 16'hFFFF) recCnt_d = recCnt_q + 16'd1;
         end else if (isHexDigit(char_i)) begin
            if (idx_q != 4'd15) idx_d = idx_q + 4'd1;
            case (idx_d)
               4'd7:    d7Zero_d = (char_i == ASC_ZERO);
               4'd8:    isEof_d  = d7Zero_q && (char_i == ASC_ONE);
               4'd10:   if (isEof_q) eofDone_d = 1'b1;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_q     <= '0;
         d7Zero_q  <= 1'b0;
         isEof_q   <= 1'b0;
         eofDone_q <= 1'b0;
         recCnt_q  <= '0;
      end else begin
         idx_q     <= idx_d;
         d7Zero_q  <= d7Zero_d;
         isEof_q   <= isEof_d;
         eofDone_q <= eofDone_d;
         recCnt_q  <= recCnt_d;
      end
   end

   assign recCnt_o  = recCnt_q;
   assign eofDone_o = eofDone_q;

endmodule

// File: rtl/hex_load_ctrl.sv
// Load sequencer: paces RX characters into the HEXBIN converter, detects end of file,
// times out stalled loads and arbitrates the program-RAM write port with the host.
module hex_load_ctrl
   import hex_pkg::*;
#(
   parameter int CHAR_GAP = 2,
   parameter int TMO_CYC  = 1000000,
   parameter int AW       = 16,
   parameter int DW       = 8
) (
   input  logic          CLK,
   input  logic          CLR,
   input  logic          START,
   input  logic          ABORT,
   input  logic [7:0]    RX_DAT,
   input  logic          RX_VLD,
   output logic          RX_RDY,
   output logic          H2B_RST,
   output logic          H2B_EN,
   output logic [7:0]    H2B_DI,
   input  logic          H2B_WE,
   input  logic [AW-1:0] H2B_AB,
   input  logic [DW-1:0] H2B_DB,
   input  logic          H2B_ERR,
   input  logic          HOST_REQ,
   input  logic [AW-1:0] HOST_AB,
   input  logic [DW-1:0] HOST_DB,
   output logic          HOST_GNT,
   output logic          MEM_WE,
   output logic [AW-1:0] MEM_AB,
   output logic [DW-1:0] MEM_DB,
   output logic          BUSY,
   output logic          DONE,
   output logic [1:0]    CAUSE,
   output logic [15:0]   WR_CNT,
   output logic [15:0]   REC_CNT
);

   localparam int GAP_LAST = (CHAR_GAP > 1) ? CHAR_GAP - 1 : 0;
   localparam int GW       = (GAP_LAST < 2) ? 1 : $clog2(GAP_LAST + 1);
   localparam int TMO_LAST = (TMO_CYC > 1) ? TMO_CYC - 1 : 0;
   localparam int TW       = (TMO_LAST < 2) ? 1 : $clog2(TMO_LAST + 1);

   logic [2:0]    state_q, state_d;
   logic [1:0]    cause_q, cause_d;
   logic [7:0]    h2bDi_q, h2bDi_d;
   logic [GW-1:0] gapCnt_q, gapCnt_d;
   logic [TW-1:0] tmoCnt_q, tmoCnt_d;
   logic [15:0]   wrCnt_q, wrCnt_d;
   logic          busy;
   logic          trkClear;
   logic          eofDone;

   assign busy = (state_q == ST_RSTC) || (state_q == ST_WAIT) ||
                 (state_q == ST_FEED) || (state_q == ST_GAP);

   // Abort beats converter error, which beats the normal flow including timeout.
   always_comb begin
      state_d  = state_q;
      cause_d  = cause_q;
      h2bDi_d  = h2bDi_q;
      gapCnt_d = gapCnt_q;
      tmoCnt_d = tmoCnt_q;
      wrCnt_d  = wrCnt_q;
      trkClear = 1'b0;
      if (busy && H2B_WE && (wrCnt_q != 16'hFFFF)) wrCnt_d = wrCnt_q + 16'd1;
      if (!busy) begin
         if (START) begin
            state_d  = ST_RSTC;
            cause_d  = CAUSE_NONE;
            wrCnt_d  = '0;
            tmoCnt_d = '0;
            trkClear = 1'b1;
         end
      end else if (ABORT) begin
         state_d = ST_FAIL;
         cause_d = CAUSE_ABORT;
      end else if (H2B_ERR) begin
         state_d = ST_FAIL;
         cause_d = CAUSE_CSUM;
      end else begin
         case (state_q)
            ST_RSTC: state_d = ST_WAIT;
            ST_WAIT: begin
               if (RX_VLD) begin
                  h2bDi_d  = RX_DAT;
                  tmoCnt_d = '0;
                  state_d  = ST_FEED;
               end else if (tmoCnt_q == TW'(TMO_LAST)) begin
                  state_d = ST_FAIL;
                  cause_d = CAUSE_TMO;
               end else begin
                  tmoCnt_d = tmoCnt_q + 1'b1;
               end
            end
            ST_FEED: begin
               gapCnt_d = '0;
               state_d  = ST_GAP;
            end
            ST_GAP: begin
               if (gapCnt_q == GW'(GAP_LAST)) state_d = eofDone ? ST_DONE : ST_WAIT;
               else gapCnt_d = gapCnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state_q  <= ST_IDLE;
         cause_q  <= CAUSE_NONE;
         h2bDi_q  <= '0;
         gapCnt_q <= '0;
         tmoCnt_q <= '0;
         wrCnt_q  <= '0;
      end else begin
         state_q  <= state_d;
         cause_q  <= cause_d;
         h2bDi_q  <= h2bDi_d;
         gapCnt_q <= gapCnt_d;
         tmoCnt_q <= tmoCnt_d;
         wrCnt_q  <= wrCnt_d;
      end
   end

   hex_rec_trk u_trk (
      .clk_i     (CLK),
      .rst_ni    (CLR),
      .clear_i   (trkClear),
      .feed_i    (state_q == ST_FEED),
      .char_i    (h2bDi_q),
      .recCnt_o  (REC_CNT),
      .eofDone_o (eofDone)
   );

   // Write port is a pure mux so neither requester sees extra latency; gated by CLR
   // so the memory is quiet while reset is held.
   always_comb begin
      MEM_WE   = 1'b0;
      MEM_AB   = '0;
      MEM_DB   = '0;
      HOST_GNT = 1'b0;
      if (CLR) begin
         if (H2B_WE) begin
            MEM_WE = 1'b1;
            MEM_AB = H2B_AB;
            MEM_DB = H2B_DB;
         end else if (HOST_REQ) begin
            MEM_WE   = 1'b1;
            MEM_AB   = HOST_AB;
            MEM_DB   = HOST_DB;
            HOST_GNT = 1'b1;
         end
      end
   end

   assign RX_RDY  = (state_q == ST_WAIT);
   assign H2B_RST = (state_q == ST_RSTC);
   assign H2B_EN  = (state_q == ST_FEED);
   assign H2B_DI  = h2bDi_q;
   assign BUSY    = busy;
   assign DONE    = (state_q == ST_DONE);
   assign CAUSE   = cause_q;
   assign WR_CNT  = wrCnt_q;

endmodule
